dual_segment_decoder: RTL
=========================

# dual_segment_decoder

Reads back the two active-low 7-segment digit buses that the on-board counter drives and recovers the displayed number, 00–99. It synchronises and debounces the segment lines and decodes each digit. It reports each newly stable value with a one-cycle strobe and optionally checks that successive values step by +1 modulo 100. It is used as a loopback monitor beside the display driver, and as a self-check when one board's display lines are wired to another board's inputs.

## Interface
- STABLE_CYCLES, 16: consecutive identical synchronised samples required before a pattern is accepted; legal range is 1 to 65535.
- i_Clk  in  1  system clock (25 MHz).
- i_Reset  in  1  one clock; reset is synchronous and active-high.
- i_Segment1_A … i_Segment1_G  in  1 each  tens digit, active low.
- i_Segment2_A … i_Segment2_G  in  1 each  units digit, active low.
- o_Tens  out  4  last accepted tens digit, 0–9.
- o_Units  out  4  last accepted units digit, 0–9.
- o_Value  out  7  o_Tens*10 + o_Units, binary.
- o_Valid  out  1  one-cycle pulse when o_Tens/o_Units/o_Value update.
- o_Error  out  1  one-cycle pulse when an accepted pattern is not a legal digit code.
- o_Locked  out  1  sticky; set at the first o_Valid after reset.
- o_Seq_Error  out  1  one-cycle pulse on a sequence violation.
- o_Seq_Err_Count  out  8  saturating count of sequence violations.

## Operation
- **Input packing:** each digit is packed as {G,F,E,D,C,B,A}, inverted to active-high, then passed through a 2-flop synchroniser; reset loads the synchroniser with all segments off.
- **Stability filter:** a counter compares the synchronised 14-bit pattern with its previous value.
  - On a mismatch, the counter reloads to 1.
  - On a match, the counter increments and saturates at STABLE_CYCLES.
  - A pattern is accepted on the cycle the counter reaches STABLE_CYCLES (STABLE_CYCLES=1 means every sample).
  - An accepted pattern equal to the last accepted pattern produces no event.
- **Decode:** each digit maps through the 10 standard codes (active-high, G..A):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - Any other pattern, including blank, is illegal.
- **State machine:**
  - IDLE: no value yet accepted. Legal accept → update outputs, pulse o_Valid, set o_Locked, go to TRACK. Illegal accept → pulse o_Error, stay in IDLE.
  - TRACK: legal accept → update outputs, pulse o_Valid, run the sequence check. Illegal accept → pulse o_Error; outputs and the last-legal value hold.
- **Sequence check:** the new value must equal (previous legal value + 1) mod 100, so 99→00 is legal.
  - On a violation, o_Seq_Error pulses in the same cycle as o_Valid, and o_Seq_Err_Count increments, saturating at 255.
  - No check is made on the first value after reset.
  - An o_Error does not reset the reference value.
- **Arithmetic:** o_Value is computed as tens*8 + tens*2 + units; no divider.

## Timing
- **Reset:** all outputs 0, state IDLE, stability counter 0, last accepted pattern cleared (the next legal or illegal pattern counts as new). Reset mid-filter discards the pending pattern.
- **Latency:** input change at edge k (first edge that samples it). The synchroniser output shows it at edge k+1; the counter reaches STABLE_CYCLES at edge k+STABLE_CYCLES; registered outputs and strobes are high from edge k+STABLE_CYCLES+1 for exactly one cycle.
- **Glitch rejection:** a glitch shorter than STABLE_CYCLES samples never produces an event, and resets the filter.
- **Strobe timing:** o_Valid and o_Error never assert in the same cycle. Back-to-back events are at least STABLE_CYCLES cycles apart.

## Configuration
- SEQ_CHECK_EN defined: the sequence checker and counter are present as described.
- SEQ_CHECK_EN undefined: o_Seq_Error and o_Seq_Err_Count are tied to 0, and no sequence logic is synthesised.

## Structure
- **Shared package (seg7_pkg):** the 10 digit code constants, the 7-bit segment pattern typedef, and the digit-to-pattern and pattern-to-digit functions. The display driver side uses the same package.
- **Sub-module:** seg7_digit_decode, combinational pattern → {digit[3:0], legal}, instantiated twice (tens, units).

## Test plan
All scenarios use STABLE_CYCLES=4 unless stated.
- **First value:** reset, drive "00" for 20 cycles → exactly one o_Valid at edge 5 after the change, o_Value=0, o_Locked=1, no o_Seq_Error.
- **Normal stepping:** drive 41, 42, 43, each held 10 cycles → three o_Valid pulses with o_Value 41, 42, 43; o_Seq_Err_Count=0.
- **Glitch rejection:** hold 42, switch to 47 for 3 cycles, return to 42 → no o_Valid, no o_Error.
- **Wrap and skip:** step 98→99→00 → no o_Seq_Error. Then 12→15 → o_Seq_Error with o_Valid (o_Value=15), count=1. Then 16 → no error.
- **Illegal pattern:** at 30, units driven to active-high 1110000 → o_Error pulse, o_Value stays 30. Then 31 → o_Valid with no o_Seq_Error.
- **Reset mid-filter:** assert i_Reset two cycles after a change, then release with the pattern held → outputs 0, and the value is accepted STABLE_CYCLES+1 edges after sampling restarts.
- **SEQ_CHECK_EN undefined:** rerun the skip case → o_Seq_Error stays 0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-high {G,F,E,D,C,B,A} digit codes plus
// encode/decode helpers used by both the display driver and the readback decoder.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] digit;
  } seg7_decode_t;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_TRACK = 1'b1
  } decode_state_t;

  localparam seg7_t SEG7_DIGIT_0 = 7'b0111111;
  localparam seg7_t SEG7_DIGIT_1 = 7'b0000110;
  localparam seg7_t SEG7_DIGIT_2 = 7'b1011011;
  localparam seg7_t SEG7_DIGIT_3 = 7'b1001111;
  localparam seg7_t SEG7_DIGIT_4 = 7'b1100110;
  localparam seg7_t SEG7_DIGIT_5 = 7'b1101101;
  localparam seg7_t SEG7_DIGIT_6 = 7'b1111101;
  localparam seg7_t SEG7_DIGIT_7 = 7'b0000111;
  localparam seg7_t SEG7_DIGIT_8 = 7'b1111111;
  localparam seg7_t SEG7_DIGIT_9 = 7'b1101111;
  localparam seg7_t SEG7_BLANK   = 7'b0000000;

  localparam logic [6:0] VALUE_MAX     = 7'd99;
  localparam logic [7:0] SEQ_COUNT_MAX = 8'hFF;

  function automatic seg7_t seg7_encode(input logic [3:0] digit);
    seg7_t pattern;
    case (digit)
      4'd0:    pattern = SEG7_DIGIT_0;
      4'd1:    pattern = SEG7_DIGIT_1;
      4'd2:    pattern = SEG7_DIGIT_2;
      4'd3:    pattern = SEG7_DIGIT_3;
      4'd4:    pattern = SEG7_DIGIT_4;
      4'd5:    pattern = SEG7_DIGIT_5;
      4'd6:    pattern = SEG7_DIGIT_6;
      4'd7:    pattern = SEG7_DIGIT_7;
      4'd8:    pattern = SEG7_DIGIT_8;
      4'd9:    pattern = SEG7_DIGIT_9;
      default: pattern = SEG7_BLANK;
    endcase
    return pattern;
  endfunction

  // Anything outside the ten standard codes, blank included, is reported illegal.
  function automatic seg7_decode_t seg7_decode(input seg7_t pattern);
    seg7_decode_t result;
    result.legal = 1'b1;
    result.digit = 4'd0;
    case (pattern)
      SEG7_DIGIT_0: result.digit = 4'd0;
      SEG7_DIGIT_1: result.digit = 4'd1;
      SEG7_DIGIT_2: result.digit = 4'd2;
      SEG7_DIGIT_3: result.digit = 4'd3;
      SEG7_DIGIT_4: result.digit = 4'd4;
      SEG7_DIGIT_5: result.digit = 4'd5;
      SEG7_DIGIT_6: result.digit = 4'd6;
      SEG7_DIGIT_7: result.digit = 4'd7;
      SEG7_DIGIT_8: result.digit = 4'd8;
      SEG7_DIGIT_9: result.digit = 4'd9;
      default:      result.legal = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one active-high segment pattern into a BCD digit
// and a legality flag.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  seg7_t      i_Pattern,
  output logic [3:0] o_Digit,
  output logic       o_Legal
);

  seg7_decode_t w_Decoded;

  always_comb begin
    w_Decoded = seg7_decode(i_Pattern);
    o_Digit   = w_Decoded.digit;
    o_Legal   = w_Decoded.legal;
  end

endmodule

// File: rtl/dual_segment_decoder.sv
// Two-digit 7-segment readback monitor: synchronise, debounce, decode, report.
// Optional SEQ_CHECK_EN adds the +1 mod 100 sequence checker and its counter.
module dual_segment_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Segment1_A,
  input  logic       i_Segment1_B,
  input  logic       i_Segment1_C,
  input  logic       i_Segment1_D,
  input  logic       i_Segment1_E,
  input  logic       i_Segment1_F,
  input  logic       i_Segment1_G,
  input  logic       i_Segment2_A,
  input  logic       i_Segment2_B,
  input  logic       i_Segment2_C,
  input  logic       i_Segment2_D,
  input  logic       i_Segment2_E,
  input  logic       i_Segment2_F,
  input  logic       i_Segment2_G,
  output logic [3:0] o_Tens,
  output logic [3:0] o_Units,
  output logic [6:0] o_Value,
  output logic       o_Valid,
  output logic       o_Error,
  output logic       o_Locked,
  output logic       o_Seq_Error,
  output logic [7:0] o_Seq_Err_Count
);

  localparam logic [15:0] STABLE_LIMIT = 16'(STABLE_CYCLES);

  logic [13:0]   w_RawPattern;
  logic [13:0]   r_Sync1;
  logic [13:0]   r_Sync2;
  logic [15:0]   r_StableCount;
  logic [15:0]   w_CountNext;
  logic [13:0]   r_LastPattern;
  logic          r_LastValid;
  logic          w_Accept;

  logic [3:0]    w_Tens;
  logic [3:0]    w_Units;
  logic          w_TensLegal;
  logic          w_UnitsLegal;
  logic          w_Legal;
  logic [6:0]    w_NewValue;

  decode_state_t r_State;
  decode_state_t w_NextState;
  logic          w_LoadValue;
  logic          w_PulseError;

  logic [3:0]    r_Tens;
  logic [3:0]    r_Units;
  logic [6:0]    r_Value;
  logic          r_Valid;
  logic          r_Error;
  logic          r_Locked;

  // Tens digit occupies the upper seven bits; inversion makes a lit segment a 1.
  assign w_RawPattern = ~{i_Segment1_G, i_Segment1_F, i_Segment1_E, i_Segment1_D,
                          i_Segment1_C, i_Segment1_B, i_Segment1_A,
                          i_Segment2_G, i_Segment2_F, i_Segment2_E, i_Segment2_D,
                          i_Segment2_C, i_Segment2_B, i_Segment2_A};

  // The count reflects the value about to enter r_Sync2, so it hits the limit
  // on the same edge that the pattern has been seen STABLE_CYCLES times.
  always_comb begin
    w_CountNext = 16'd1;
    if (r_Sync1 == r_Sync2) begin
      if (r_StableCount >= STABLE_LIMIT) begin
        w_CountNext = STABLE_LIMIT;
      end else begin
        w_CountNext = r_StableCount + 16'd1;
      end
    end
  end

  // A saturated counter re-presents the same pattern every cycle; only a
  // pattern different from the last accepted one becomes an event.
  assign w_Accept = (r_StableCount == STABLE_LIMIT) &&
                    (!r_LastValid || (r_Sync2 != r_LastPattern));

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_Sync1       <= '0;
      r_Sync2       <= '0;
      r_StableCount <= '0;
      r_LastPattern <= '0;
      r_LastValid   <= 1'b0;
    end else begin
      r_Sync1       <= w_RawPattern;
      r_Sync2       <= r_Sync1;
      r_StableCount <= w_CountNext;
      if (w_Accept) begin
        r_LastPattern <= r_Sync2;
        r_LastValid   <= 1'b1;
      end
    end
  end

  seg7_digit_decode u_TensDecode (
    .i_Pattern (r_Sync2[13:7]),
    .o_Digit   (w_Tens),
    .o_Legal   (w_TensLegal)
  );

  seg7_digit_decode u_UnitsDecode (
    .i_Pattern (r_Sync2[6:0]),
    .o_Digit   (w_Units),
    .o_Legal   (w_UnitsLegal)
  );

  assign w_Legal    = w_TensLegal && w_UnitsLegal;
  assign w_NewValue = {w_Tens, 3'b000} + {2'b00, w_Tens, 1'b0} + {3'b000, w_Units};

  always_comb begin
    w_NextState  = r_State;
    w_LoadValue  = 1'b0;
    w_PulseError = 1'b0;
    case (r_State)
      ST_IDLE: begin
        if (w_Accept) begin
          if (w_Legal) begin
            w_LoadValue = 1'b1;
            w_NextState = ST_TRACK;
          end else begin
            w_PulseError = 1'b1;
          end
        end
      end
      ST_TRACK: begin
        if (w_Accept) begin
          if (w_Legal) begin
            w_LoadValue = 1'b1;
          end else begin
            w_PulseError = 1'b1;
          end
        end
      end
      default: w_NextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_State  <= ST_IDLE;
      r_Tens   <= '0;
      r_Units  <= '0;
      r_Value  <= '0;
      r_Valid  <= 1'b0;
      r_Error  <= 1'b0;
      r_Locked <= 1'b0;
    end else begin
      r_State <= w_NextState;
      r_Valid <= w_LoadValue;
      r_Error <= w_PulseError;
      if (w_LoadValue) begin
        r_Tens   <= w_Tens;
        r_Units  <= w_Units;
        r_Value  <= w_NewValue;
        r_Locked <= 1'b1;
      end
    end
  end

  assign o_Tens   = r_Tens;
  assign o_Units  = r_Units;
  assign o_Value  = r_Value;
  assign o_Valid  = r_Valid;
  assign o_Error  = r_Error;
  assign o_Locked = r_Locked;

`ifdef SEQ_CHECK_EN
  logic [6:0] w_ExpectedNext;
  logic       w_SeqViolation;
  logic       r_SeqError;
  logic [7:0] r_SeqErrCount;

  // r_Value still holds the previous legal value here; illegal patterns never touch it.
  assign w_ExpectedNext = (r_Value == VALUE_MAX) ? 7'd0 : (r_Value + 7'd1);
  assign w_SeqViolation = w_LoadValue && (r_State == ST_TRACK) &&
                          (w_NewValue != w_ExpectedNext);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_SeqError    <= 1'b0;
      r_SeqErrCount <= '0;
    end else begin
      r_SeqError <= w_SeqViolation;
      if (w_SeqViolation && (r_SeqErrCount != SEQ_COUNT_MAX)) begin
        r_SeqErrCount <= r_SeqErrCount + 8'd1;
      end
    end
  end

  assign o_Seq_Error     = r_SeqError;
  assign o_Seq_Err_Count = r_SeqErrCount;
`else
  assign o_Seq_Error     = 1'b0;
  assign o_Seq_Err_Count = 8'd0;
`endif

endmodule
